// File: rtl/serial_tree_comparator.sv
// Sequential MSB-first magnitude comparator for two unsigned operands.
// One 2-bit digit pair is examined per clock; the first unequal digit
// decides the result. Reports M (a > b) and I (a == b) behind a
// start/ready/done handshake.
module serial_tree_comparator #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             M,
  output logic             I
);

  localparam int D     = WIDTH / 2;
  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;

  typedef enum logic {
    IDLE,
    COMPARE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IDX_W-1:0] idx;
  logic             decided;
  logic             res_m;

  logic [1:0]       ad;
  logic [1:0]       bd;
  logic             dig_gt;
  logic             dig_eq;
  logic             last_digit;
  logic             finish;
  logic             fin_m;
  logic             fin_i;

  // Pure 2-bit unsigned compare slice: returns {greater, equal}.
  function automatic logic [1:0] dig_cmp(input logic [1:0] x, input logic [1:0] y);
    logic gt;
    logic eq;
    gt = (x[1] & ~y[1]) | ((x[1] ~^ y[1]) & x[0] & ~y[0]);
    eq = (x[1] ~^ y[1]) & (x[0] ~^ y[0]);
    return {gt, eq};
  endfunction

  // Digit-pair select and compare; decides whether this edge ends the scan.
  always_comb begin
    ad         = a_reg[2*int'(idx) +: 2];
    bd         = b_reg[2*int'(idx) +: 2];
    {dig_gt, dig_eq} = dig_cmp(ad, bd);
    last_digit = (idx == '0);
    // Without early exit the scan always runs to digit 0; an earlier
    // unequal digit has already frozen the result in decided/res_m.
    finish     = (state == COMPARE) && (last_digit || (EARLY_EXIT && !dig_eq));
    fin_m      = decided ? res_m : dig_gt;
    fin_i      = decided ? 1'b0  : dig_eq;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = COMPARE;
      COMPARE: if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, digit index, frozen result and published outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      idx     <= '0;
      decided <= 1'b0;
      res_m   <= 1'b0;
      done    <= 1'b0;
      M       <= 1'b0;
      I       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            idx     <= IDX_W'(D - 1);
            decided <= 1'b0;
            res_m   <= 1'b0;
            M       <= 1'b0;
            I       <= 1'b0;
          end
        end
        COMPARE: begin
          if (finish) begin
            M    <= fin_m;
            I    <= fin_i;
            done <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
            if (!decided && !dig_eq) begin
              decided <= 1'b1;
              res_m   <= dig_gt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == COMPARE);

endmodule
